// File: rtl/seg7_scan_driver_if.sv
// Load/display bundle between the result registers and the seven-segment driver.
// The master drives the load strobe and the value; the slave returns status and the pins.
interface seg7_scan_driver_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned WIDTH  = 14
);
    logic              load;
    logic [WIDTH-1:0]  value;
    logic              hex_mode;
    logic              blank_lz;
    logic              busy;
    logic              overflow;
    logic [0:6]        seg;
    logic [DIGITS-1:0] an;

    modport master (
        output load, value, hex_mode, blank_lz,
        input  busy, overflow, seg, an
    );

    modport slave (
        input  load, value, hex_mode, blank_lz,
        output busy, overflow, seg, an
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multi-digit seven-segment driver: sequential double-dabble or hex split on load,
// committed atomically into display registers that are scanned onto one active-low bus.
module seg7_scan_driver #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned WIDTH   = 14,
    parameter int unsigned CLK_DIV = 50000
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p = 1;
        for (int unsigned k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned DEC_LIMIT = pow10(DIGITS);

    function automatic logic [0:6] glyph(input logic [3:0] d);
        logic [0:6] g;
        g = 7'b1111111;
        case (d)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            4'hF: g = 7'b0111000;
        endcase
        return g;
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t            state_q;
    logic              busy_q;
    logic [WIDTH-1:0]  bin_q;
    logic [BW-1:0]     bcd_q;
    logic [CW-1:0]     iter_q;
    logic              blz_q;
    logic              ovf_q;
    logic [BW-1:0]     disp_digits_q, disp_digits_d;
    logic [DIGITS-1:0] disp_blank_q, disp_blank_d;
    logic              overflow_q, overflow_d;
    logic [DW-1:0]     div_q, div_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [0:6]        seg_q, seg_d;

    logic [63:0]       value_ext_c;
    logic              ovf_load_c;
    logic [BW-1:0]     adj_c;
    logic [BW-1:0]     bcd_shift_c;
    logic [DIGITS-1:0] blank_c;
    logic              lead_c;
    logic [3:0]        digit_c;

    // Overflow is decided once at load against constant limits.
    assign value_ext_c = 64'(bus.value);
    assign ovf_load_c  = bus.hex_mode ? ((value_ext_c >> BW) != 64'd0)
                                      : (value_ext_c >= DEC_LIMIT);

    // One double-dabble step: add-3 correction then shift in the next binary bit.
    always_comb begin
        adj_c = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (adj_c[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = adj_c[4*i +: 4] + 4'd3;
        end
        bcd_shift_c = {adj_c[BW-2:0], bin_q[WIDTH-1]};
    end

    // Leading-zero flags: a digit blanks only if it and every higher digit are zero.
    always_comb begin
        blank_c = '0;
        lead_c  = blz_q;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            lead_c     = lead_c && (bcd_q[4*i +: 4] == 4'd0);
            blank_c[i] = lead_c;
        end
    end

    // Display next-state and scan; seg/an are built from the post-commit contents.
    always_comb begin
        disp_digits_d = disp_digits_q;
        disp_blank_d  = disp_blank_q;
        overflow_d    = overflow_q;
        if (state_q == COMMIT) begin
            disp_digits_d = bcd_q;
            disp_blank_d  = blank_c;
            overflow_d    = ovf_q;
        end
        div_d = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
        idx_d = idx_q;
        if (div_q == DW'(CLK_DIV - 1)) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        an_d    = ~(DIGITS'(1) << idx_d);
        digit_c = disp_digits_d[4*int'(idx_d) +: 4];
        if (overflow_d)               seg_d = 7'b1111110;
        else if (disp_blank_d[idx_d]) seg_d = 7'b1111111;
        else                          seg_d = glyph(digit_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            bin_q         <= '0;
            bcd_q         <= '0;
            iter_q        <= '0;
            blz_q         <= 1'b0;
            ovf_q         <= 1'b0;
            disp_digits_q <= '0;
            disp_blank_q  <= '0;
            overflow_q    <= 1'b0;
            div_q         <= '0;
            idx_q         <= '0;
            an_q          <= ~DIGITS'(1);
            seg_q         <= 7'b0000001;
        end else begin
            disp_digits_q <= disp_digits_d;
            disp_blank_q  <= disp_blank_d;
            overflow_q    <= overflow_d;
            div_q         <= div_d;
            idx_q         <= idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        busy_q <= 1'b1;
                        blz_q  <= bus.blank_lz;
                        ovf_q  <= ovf_load_c;
                        if (bus.hex_mode) begin
                            bcd_q   <= BW'(bus.value);
                            state_q <= COMMIT;
                        end else begin
                            bcd_q   <= '0;
                            bin_q   <= bus.value;
                            iter_q  <= '0;
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    bcd_q  <= bcd_shift_c;
                    bin_q  <= bin_q << 1;
                    iter_q <= iter_q + CW'(1);
                    if (iter_q == CW'(WIDTH - 1)) state_q <= COMMIT;
                end
                COMMIT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against an arithmetic model of the displayed digits.
module tb_seg7_scan_driver;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned WIDTH   = 14;
    localparam int unsigned CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int unsigned cyc;

    int unsigned m_val;
    bit          m_hex;
    bit          m_blz;
    logic [0:6]  glyph_tab [16];

    seg7_scan_driver_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

    seg7_scan_driver #(.DIGITS(DIGITS), .WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the scan position follows from this alone.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:6] exp_seg(input int i);
        longint unsigned base, p, lim;
        base = m_hex ? 16 : 10;
        p = 1;
        lim = 1;
        for (int k = 0; k < i; k++) p = p * base;
        for (int k = 0; k < int'(DIGITS); k++) lim = lim * base;
        if (longint'(m_val) >= lim) return 7'b1111110;
        if (m_blz && i > 0 && longint'(m_val) < p) return 7'b1111111;
        return glyph_tab[(longint'(m_val) / p) % base];
    endfunction

    task automatic scan_check(input string tag);
        int         idx;
        logic [3:0] ea;
        for (int k = 0; k < 4 * int'(CLK_DIV * DIGITS) / 4; k++) begin
            idx = int'((cyc / CLK_DIV) % DIGITS);
            ea  = ~(4'(1) << idx);
            check({tag, "_an"}, 32'(bus.an), 32'(ea));
            check({tag, "_seg"}, 32'(bus.seg), 32'(exp_seg(idx)));
            @(negedge clk);
        end
    endtask

    // Pulses load; optionally retries a load of 42 while busy at step intr.
    task automatic do_load(input int unsigned v, input bit hex, input bit blz,
                           input int intr, input string tag);
        int n;
        bus.value    = WIDTH'(v);
        bus.hex_mode = hex;
        bus.blank_lz = blz;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            if (n == intr) begin
                bus.value = WIDTH'(42);
                bus.load  = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        bus.load = 1'b0;
        check({tag, "_busy_len"}, 32'(n), hex ? 32'd1 : 32'(WIDTH + 1));
        m_val = v;
        m_hex = hex;
        m_blz = blz;
        @(negedge clk);
        check({tag, "_ovf"}, 32'(bus.overflow),
              32'(hex ? (v >= 65536) : (v >= 10000)));
        scan_check(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned v;
        int          sel;
        int          intr;
        bit          hx;
        glyph_tab[0]  = 7'b0000001; glyph_tab[1]  = 7'b1001111;
        glyph_tab[2]  = 7'b0010010; glyph_tab[3]  = 7'b0000110;
        glyph_tab[4]  = 7'b1001100; glyph_tab[5]  = 7'b0100100;
        glyph_tab[6]  = 7'b0100000; glyph_tab[7]  = 7'b0001111;
        glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0000100;
        glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b1100000;
        glyph_tab[12] = 7'b0110001; glyph_tab[13] = 7'b1000010;
        glyph_tab[14] = 7'b0110000; glyph_tab[15] = 7'b0111000;
        m_val = 0; m_hex = 0; m_blz = 0;

        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.hex_mode = 1'b0;
        bus.blank_lz = 1'b0;
        #1;
        check("rst_an", 32'(bus.an), 32'h0000000e);
        check("rst_seg", 32'(bus.seg), 32'h00000001);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        scan_check("init");

        do_load(1234, 0, 0, -1, "d1234");
        do_load(7, 0, 1, -1, "d7_blz");
        do_load(7, 0, 0, -1, "d7");
        do_load(0, 0, 1, -1, "d0_blz");
        do_load(14'h3A5F, 1, 0, -1, "h3a5f");
        do_load(14'h000C, 1, 1, -1, "h000c_blz");
        do_load(10000, 0, 1, -1, "d10000");
        do_load(9999, 0, 0, -1, "d9999");
        do_load(1234, 0, 0, 4, "d1234_ign");
        do_load(5678, 0, 0, 14, "d5678_ign_last");
        do_load(14'h1F, 1, 0, 0, "h1f_ign");

        // Asynchronous reset in the middle of a conversion.
        bus.value    = WIDTH'(1234);
        bus.hex_mode = 1'b0;
        bus.blank_lz = 1'b0;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_an", 32'(bus.an), 32'h0000000e);
        check("mid_rst_seg", 32'(bus.seg), 32'h00000001);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        m_val = 0; m_hex = 0; m_blz = 0;
        scan_check("post_rst");
        do_load(42, 0, 0, -1, "d42_after_rst");

        for (int r = 0; r < 24; r++) begin
            sel = int'($urandom % 4);
            case (sel)
                0:       v = $urandom_range(16383, 0);
                1:       v = $urandom_range(9, 0);
                2:       v = $urandom_range(999, 0);
                default: v = $urandom_range(10010, 9990);
            endcase
            hx   = 1'($urandom % 2);
            intr = ($urandom % 3 == 0) ? int'($urandom_range(hx ? 0 : 14, 0)) : -1;
            do_load(v, hx, 1'($urandom % 2), intr, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multi-digit seven-segment display driver. It accepts a binary value on a load strobe and converts it to BCD with a sequential double-dabble engine, or splits it into hex nibbles. It then time-multiplexes the digits onto one active-low segment bus with per-digit anode enables. It sits between the datapath result registers and the board display pins, and supersedes the single-digit combinational BCD decoder.

## Interface
- DIGITS, 4, number of displayed digits (1..8)
- WIDTH, 14, binary input width (1..27)
- CLK_DIV, 50000, clock cycles per digit refresh slot (>=2)

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high; one clock domain only
- load  in  1  start conversion of `value`; accepted only when busy=0
- value  in  WIDTH  unsigned binary value to display
- hex_mode  in  1  1 = hexadecimal digits, 0 = decimal; sampled on accepted load
- blank_lz  in  1  1 = blank leading zeros; sampled on accepted load
- busy  out  1  conversion in progress
- overflow  out  1  last accepted value does not fit in DIGITS digits
- seg  out  [0:6]  segments a..g, seg[0]=a, active-low, registered
- an  out  DIGITS  digit enables, active-low, one-hot-low, registered

## Operation
- Reset values:
  - busy=0, overflow=0
  - display digit registers all 0, blank flags clear
  - scan index=0, divider=0
  - an = all ones except an[0]=0
  - seg = 7'b0000001 (glyph "0")
- States: IDLE, CONV, COMMIT.
  - IDLE: load=1 captures value, hex_mode and blank_lz.
  - IDLE to CONV on a decimal load; IDLE to COMMIT on a hex load.
- CONV:
  - Runs WIDTH shift iterations over a 4*DIGITS-bit BCD register plus the shifted value.
  - Before each shift, add 3 to every BCD nibble >= 5.
  - Goes to COMMIT after the WIDTH-th iteration.
- Hex mode: digit i = value[4i+3:4i], zero-extended. Bits above 4*DIGITS set overflow.
- Decimal overflow: captured value >= 10^DIGITS. The comparison is done at load, against a constant computed from the parameters.
- COMMIT:
  - Copies the converted digits, overflow and blank flags into the display registers.
  - Returns to IDLE.
  - Display contents change only here; a conversion never shows partial results.
- Blanking:
  - With blank_lz=1, every digit above the most significant nonzero digit shows 7'b1111111.
  - Digit 0 is never blanked.
- Overflow display: every digit shows a dash, 7'b1111110, regardless of blank_lz.
- Glyphs (abcdefg, 0 = lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Scan:
  - The divider counts 0..CLK_DIV-1 and wraps, producing a one-cycle tick at CLK_DIV-1.
  - On each tick the scan index increments, wrapping from DIGITS-1 to 0.
  - an and seg are registered from the new index.
  - Exactly one anode is low at all times.
- load while busy=1 is ignored: no queuing, no effect on the running conversion.

## Timing
- Load accepted at edge T: busy=1 from T.
  - Decimal: CONV occupies edges T+1..T+WIDTH; COMMIT at T+WIDTH+1. Display registers and overflow update, and busy falls, at that same edge.
  - Hex: COMMIT at T+1; busy is high for exactly one cycle.
- load on the same edge busy falls is ignored. The earliest next accept is one cycle after busy=0 is seen.
- New digit contents reach seg at the next scan register update, which is at most one cycle later for the currently selected digit.
- The scan runs continuously and is independent of conversions. A COMMIT coinciding with a tick shows the new data for the new index.
- rst mid-conversion:
  - Aborts CONV and restores all reset values immediately (asynchronous).
  - The display does not retain previous contents.
  - The first load after rst deasserts is accepted normally.

## Test plan
All scenarios use DIGITS=4, WIDTH=14, CLK_DIV=4.
1. Reset: assert rst mid-run -> an=4'b1110, seg=0000001, busy=0, overflow=0, at once with no clock edge.
2. Decimal load of 1234, blank_lz=0:
   - busy is high for 15 cycles.
   - The scan then gives an=1110 seg=1001100, an=1101 seg=0000110, an=1011 seg=0010010, an=0111 seg=1001111, each held 4 cycles.
3. Decimal load of 7, blank_lz=1 -> digit0 seg=0001111; digits 1..3 seg=1111111. With blank_lz=0, digits 1..3 show 0000001.
4. Hex load of 14'h3A5F -> busy high for 1 cycle; digits 0..3 show F=0111000, 5=0100100, A=0001000, 3=0000110.
5. Decimal load of 10000 -> overflow=1, all digits 1111110. A following load of 9999 clears overflow and shows 9=0000100 on all digits.
6. Conversion interruptions:
   - load of 42 at the 5th cycle of the 1234 conversion is ignored; the display shows 1234.
   - rst at the 5th cycle restores reset values; a subsequent load of 42 shows 2,4 on digits 0,1.
